// File: rtl/tetris_ctrl.sv
// tetris_ctrl
// Game-sequencing controller for the Tetris datapath. Steps the datapath
// through NEWBOARD, GEN, MOVE, LAND, CLEAR and GAMEOVER. It paces gravity
// drops in MOVE, arbitrates the left/right/rotate requests into one move
// stream, and counts spawned pieces.
//
// State table (encoding is shared with the datapath):
//   state     | code | meaning
//   GEN       | 000  | spawn a piece, or detect a blocked spawn area
//   MOVE      | 001  | piece in play; move slots every STEP_CYCLES clocks
//   LAND      | 010  | piece landed after a drop
//   CLEAR     | 011  | row clear / redraw for CLEAR_CYCLES clocks
//   NEWBOARD  | 100  | fresh board; piece count cleared
//   GAMEOVER  | 101  | waits for start
//
// Ports:
//   clka         in   sole clock, rising edge
//   restart      in   asynchronous active-high reset
//   start        in   level; leaves GAMEOVER
//   btn_left     in   single-cycle move-left request
//   btn_right    in   single-cycle move-right request
//   btn_rotate   in   single-cycle rotate request
//   touched      in   piece landed after the last drop
//   error        in   datapath clear/redraw error
//   board_in     in   current board; bits [7:0] are the spawn rows
//   state        out  current phase (table above)
//   old_state    out  state of the previous cycle
//   move         out  0 drop, 1 left, 2 right, 3 rotate
//   move_valid   out  one-cycle strobe qualifying move
//   piece_count  out  pieces spawned, saturating at 255
module tetris_ctrl #(
  parameter int STEP_CYCLES  = 4,
  parameter int DROP_STEPS   = 4,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic        clka,
  input  logic        restart,
  input  logic        start,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_rotate,
  input  logic        touched,
  input  logic        error,
  input  logic [31:0] board_in,
  output logic [2:0]  state,
  output logic [2:0]  old_state,
  output logic [1:0]  move,
  output logic        move_valid,
  output logic [7:0]  piece_count
);

  localparam logic [2:0] S_GEN      = 3'b000;
  localparam logic [2:0] S_MOVE     = 3'b001;
  localparam logic [2:0] S_LAND     = 3'b010;
  localparam logic [2:0] S_CLEAR    = 3'b011;
  localparam logic [2:0] S_NEWBOARD = 3'b100;
  localparam logic [2:0] S_GAMEOVER = 3'b101;

  localparam logic [1:0] MV_DROP   = 2'd0;
  localparam logic [1:0] MV_LEFT   = 2'd1;
  localparam logic [1:0] MV_RIGHT  = 2'd2;
  localparam logic [1:0] MV_ROTATE = 2'd3;

  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int DROP_W = (DROP_STEPS > 1) ? $clog2(DROP_STEPS) : 1;
  localparam int CLR_W  = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_PRE  = STEP_W'(STEP_CYCLES - 2);
  localparam logic [DROP_W-1:0] DROP_LAST = DROP_W'(DROP_STEPS - 1);
  localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(CLEAR_CYCLES - 1);

  logic [2:0]        state_nx;
  logic [STEP_W-1:0] step_cnt;
  logic [DROP_W-1:0] drop_cnt;
  logic [CLR_W-1:0]  clr_cnt;
  logic              pend_l;
  logic              pend_r;
  logic              pend_rot;
  logic              touch_win;
  logic              slot_issue;
  logic              drop_slot;
  logic              can_set;
  logic              enter_gen;
  logic              issue_rot;
  logic              issue_l;
  logic              issue_r;

  // Only the spawn rows matter to sequencing.
  logic unused_board;
  assign unused_board = ^board_in[31:8];

  always_comb begin
    state_nx = state;
    case (state)
      S_NEWBOARD: state_nx = S_GEN;
      S_GEN:      state_nx = (board_in[7:0] != 8'd0) ? S_GAMEOVER : S_MOVE;
      S_MOVE:     if (touch_win && touched) state_nx = S_LAND;
      S_LAND:     state_nx = S_CLEAR;
      S_CLEAR: begin
        if (error)                  state_nx = S_GAMEOVER;
        else if (clr_cnt == CLR_LAST) state_nx = S_GEN;
      end
      S_GAMEOVER: if (start) state_nx = S_NEWBOARD;
      default:    state_nx = S_NEWBOARD;
    endcase
  end

  // The move registers are loaded one edge ahead of the slot so that the
  // strobe is visible during the slot cycle itself (step_cnt == STEP_LAST).
  // At that edge drop_cnt already holds the slot's index in the period.
  // No strobe is issued on the edge that leaves MOVE.
  assign slot_issue = (state == S_MOVE) && (state_nx == S_MOVE) &&
                      (step_cnt == STEP_PRE);
  assign drop_slot  = (drop_cnt == DROP_LAST);
  assign issue_rot  = slot_issue && !drop_slot && pend_rot;
  assign issue_l    = slot_issue && !drop_slot && !pend_rot && pend_l;
  assign issue_r    = slot_issue && !drop_slot && !pend_rot && !pend_l && pend_r;

  assign can_set    = (state != S_GAMEOVER) && (state != S_NEWBOARD);
  assign enter_gen  = (state_nx == S_GEN) && (state != S_GEN);

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      state     <= S_NEWBOARD;
      old_state <= S_NEWBOARD;
    end else begin
      state     <= state_nx;
      old_state <= state;
    end
  end

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      step_cnt <= '0;
      drop_cnt <= '0;
    end else if (state != S_MOVE) begin
      step_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
      if (step_cnt == STEP_LAST)
        drop_cnt <= (drop_cnt == DROP_LAST) ? '0 : drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clka or posedge restart) begin
    if (restart)
      clr_cnt <= '0;
    else if (state != S_CLEAR || clr_cnt == CLR_LAST)
      clr_cnt <= '0;
    else
      clr_cnt <= clr_cnt + 1'b1;
  end

  // A new request in the same cycle as its clear wins, so nothing is lost.
  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      pend_rot <= 1'b0;
      pend_l   <= 1'b0;
      pend_r   <= 1'b0;
    end else begin
      pend_rot <= (btn_rotate && can_set) || (pend_rot && !(enter_gen || issue_rot));
      pend_l   <= (btn_left   && can_set) || (pend_l   && !(enter_gen || issue_l));
      pend_r   <= (btn_right  && can_set) || (pend_r   && !(enter_gen || issue_r));
    end
  end

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      move       <= MV_DROP;
      move_valid <= 1'b0;
    end else begin
      move_valid <= 1'b0;
      if (slot_issue) begin
        if (drop_slot) begin
          move       <= MV_DROP;
          move_valid <= 1'b1;
        end else if (pend_rot) begin
          move       <= MV_ROTATE;
          move_valid <= 1'b1;
        end else if (pend_l) begin
          move       <= MV_LEFT;
          move_valid <= 1'b1;
        end else if (pend_r) begin
          move       <= MV_RIGHT;
          move_valid <= 1'b1;
        end
      end
    end
  end

  // touched is only meaningful in the cycle right after a drop strobe.
  always_ff @(posedge clka or posedge restart) begin
    if (restart)
      touch_win <= 1'b0;
    else
      touch_win <= (state == S_MOVE) && move_valid && (move == MV_DROP);
  end

  // Cleared on entry so the count already reads zero while in NEWBOARD.
  always_ff @(posedge clka or posedge restart) begin
    if (restart)
      piece_count <= 8'd0;
    else if (state_nx == S_NEWBOARD)
      piece_count <= 8'd0;
    else if (state == S_GEN && state_nx == S_MOVE && piece_count != 8'hFF)
      piece_count <= piece_count + 8'd1;
  end

endmodule
